// File: rtl/dma_pkg.sv
// dma_pkg: shared constants, FSM state encoding and the arbitration helper
// for the DMA priority resolver.
`default_nettype none

package dma_pkg;

  localparam int NUM_CH      = 4;
  localparam int CMD_DISABLE = 2;
  localparam int CMD_ROTATE  = 4;
  localparam int CMD_DREQ_LO = 6;
  localparam int CMD_DACK_HI = 7;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_HOLD_REQ = 2'd1,
    ST_GRANT    = 2'd2
  } state_t;

  // Scans ptr, ptr+1, ... (mod 4); fixed priority is simply ptr = 0.
  function automatic logic [1:0] pick_winner(input logic [NUM_CH-1:0] req,
                                             input logic [1:0]        ptr);
    logic [1:0] idx;
    logic [1:0] win;
    logic       found;
    win   = ptr;
    found = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = ptr + 2'(i);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dma_priority_resolver_if.sv
// dma_priority_resolver_if: request/hold/acknowledge bundle between the
// register file, timing control and the priority resolver.
`default_nettype none

interface dma_priority_resolver_if;
  import dma_pkg::*;

  logic [NUM_CH-1:0] DREQ;
  logic              HLDA;
  logic [7:0]        commandReg;
  logic [7:0]        requestReg;
  logic [7:0]        maskReg;
  logic              svcDone;
  logic              HRQ;
  logic [NUM_CH-1:0] DACK;
  logic [1:0]        activeCh;
  logic              chValid;

  modport slave (
    input  DREQ, HLDA, commandReg, requestReg, maskReg, svcDone,
    output HRQ, DACK, activeCh, chValid
  );

  modport master (
    output DREQ, HLDA, commandReg, requestReg, maskReg, svcDone,
    input  HRQ, DACK, activeCh, chValid
  );

endinterface

`default_nettype wire

// File: rtl/dma_dreq_sync.sv
// dma_dreq_sync: multi-bit flop-chain synchronizer for asynchronous DREQ lines.
`default_nettype none

module dma_dreq_sync #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] i_async,
  output logic [WIDTH-1:0] o_sync
);

  logic [STAGES-1:0][WIDTH-1:0] r_chain;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) r_chain[0] <= '0;
    else       r_chain[0] <= i_async;
  end

  for (genvar s = 1; s < STAGES; s++) begin : g_stage
    always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) r_chain[s] <= '0;
      else       r_chain[s] <= r_chain[s-1];
    end
  end

  assign o_sync = r_chain[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/dma_priority_resolver.sv
// dma_priority_resolver: synchronizes DREQ, arbitrates fixed/rotating priority
// and runs the HRQ/HLDA/DACK hold-grant handshake.
`default_nettype none

module dma_priority_resolver
  import dma_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input logic                     CLK,
  input logic                     RESET,
  dma_priority_resolver_if.slave  bus
);

  logic [NUM_CH-1:0] w_sync;
  logic [NUM_CH-1:0] w_active;
  logic [NUM_CH-1:0] w_eff;
  logic [1:0]        w_winner;
  logic              w_disable;
  logic              w_rotate;

  state_t            r_state;
  state_t            w_next_state;
  logic              r_hrq;
  logic [NUM_CH-1:0] r_grant_vec;
  logic [NUM_CH-1:0] w_next_grant;
  logic [1:0]        r_active_ch;
  logic [1:0]        w_next_ch;
  logic              r_ch_valid;
  logic              w_next_valid;
  logic [1:0]        r_prio_ptr;
  logic [1:0]        w_next_ptr;

  dma_dreq_sync #(
    .WIDTH  (NUM_CH),
    .STAGES (SYNC_STAGES)
  ) u_dreq_sync (
    .CLK     (CLK),
    .RESET   (RESET),
    .i_async (bus.DREQ),
    .o_sync  (w_sync)
  );

  assign w_disable = bus.commandReg[CMD_DISABLE];
  assign w_rotate  = bus.commandReg[CMD_ROTATE];
  assign w_active  = w_sync ^ {NUM_CH{bus.commandReg[CMD_DREQ_LO]}};
  assign w_eff     = (w_active & ~bus.maskReg[NUM_CH-1:0]) | bus.requestReg[NUM_CH-1:0];
  assign w_winner  = pick_winner(w_eff, w_rotate ? r_prio_ptr : 2'd0);

  always_comb begin
    w_next_state = r_state;
    w_next_grant = r_grant_vec;
    w_next_ch    = r_active_ch;
    w_next_valid = r_ch_valid;
    w_next_ptr   = r_prio_ptr;
    unique case (r_state)
      ST_IDLE: begin
        if (!w_disable && (w_eff != '0)) w_next_state = ST_HOLD_REQ;
      end
      ST_HOLD_REQ: begin
        if (w_disable || (w_eff == '0)) begin
          w_next_state = ST_IDLE;
        end else if (bus.HLDA) begin
          w_next_state = ST_GRANT;
          w_next_grant = 4'b0001 << w_winner;
          w_next_ch    = w_winner;
          w_next_valid = 1'b1;
        end
      end
      ST_GRANT: begin
        // Winner is locked; only end of service or loss of HLDA releases it.
        if (bus.svcDone || !bus.HLDA) begin
          w_next_state = ST_IDLE;
          w_next_grant = '0;
          w_next_ch    = 2'd0;
          w_next_valid = 1'b0;
          if (bus.svcDone && w_rotate) w_next_ptr = r_active_ch + 2'd1;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
        w_next_grant = '0;
        w_next_ch    = 2'd0;
        w_next_valid = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state     <= ST_IDLE;
      r_hrq       <= 1'b0;
      r_grant_vec <= '0;
      r_active_ch <= 2'd0;
      r_ch_valid  <= 1'b0;
      r_prio_ptr  <= 2'd0;
    end else begin
      r_state     <= w_next_state;
      r_hrq       <= (w_next_state != ST_IDLE);
      r_grant_vec <= w_next_grant;
      r_active_ch <= w_next_ch;
      r_ch_valid  <= w_next_valid;
      r_prio_ptr  <= w_next_ptr;
    end
  end

  assign bus.HRQ      = r_hrq;
  assign bus.DACK     = r_grant_vec ^ {NUM_CH{~bus.commandReg[CMD_DACK_HI]}};
  assign bus.activeCh = r_active_ch;
  assign bus.chValid  = r_ch_valid;

  logic w_unused_bits;
  assign w_unused_bits = ^{bus.commandReg[1:0], bus.commandReg[3], bus.commandReg[5],
                           bus.requestReg[7:4], bus.maskReg[7:4]};

endmodule

`default_nettype wire

// File: doc/dma_priority_resolver.md
DMA_PRIORITY_RESOLVER -- requirements
Module: dma_priority_resolver

Interface
REQ-001 The block SHALL have one parameter, SYNC_STAGES, default 2, which sets the number of DREQ synchronizer flops (minimum 2).
REQ-002 The block SHALL use port CLK, input, 1 bit, as the single clock; all flops are on its rising edge.
REQ-003 The block SHALL use port RESET, input, 1 bit, as the reset, which is asynchronous and active-high.
REQ-004 The block SHALL have port DREQ, input, 4 bits, carrying the raw asynchronous channel requests; polarity is set by commandReg[6].
REQ-005 The block SHALL have port HLDA, input, 1 bit, carrying the CPU hold acknowledge.
REQ-006 The block SHALL have port commandReg, input, 8 bits, from the register file PR view: bit2 = controller disable, bit4 = rotating priority, bit6 = DREQ active-low, bit7 = DACK active-high.
REQ-007 The block SHALL have port requestReg, input, 8 bits; bits 3:0 are the software requests.
REQ-008 The block SHALL have port maskReg, input, 8 bits; bits 3:0 are the channel masks, where 1 = masked.
REQ-009 The block SHALL have port svcDone, input, 1 bit, a single-cycle pulse from timing control marking the end of service on the granted channel.
REQ-010 The block SHALL have port HRQ, output, 1 bit, the hold request to the CPU.
REQ-011 The block SHALL have port DACK, output, 4 bits, the channel acknowledges; polarity is set by commandReg[7].
REQ-012 The block SHALL have port activeCh, output, 2 bits, the index of the granted channel.
REQ-013 The block SHALL have port chValid, output, 1 bit, high while a channel is granted; timing control qualifies activeCh with it.

Function
REQ-014 Each DREQ bit SHALL pass through SYNC_STAGES flops and then be normalized: active = sync XOR commandReg[6].
REQ-015 The effective request vector SHALL be effReq = (activeDreq AND NOT maskReg[3:0]) OR requestReg[3:0]; software requests bypass the mask.
REQ-016 The FSM SHALL have three states: IDLE, HOLD_REQ and GRANT.
REQ-017 In IDLE, when commandReg[2]=0 and effReq is nonzero, the FSM SHALL move to HOLD_REQ at the next edge, and HRQ SHALL be registered high on that same edge.
REQ-018 In HOLD_REQ with effReq=0 (request withdrawn), the FSM SHALL return to IDLE and drop HRQ at the next edge.
REQ-019 In HOLD_REQ with commandReg[2]=1, the FSM SHALL return to IDLE and drop HRQ at the next edge.
REQ-020 In HOLD_REQ on the first cycle HLDA=1 with effReq nonzero, the FSM SHALL arbitrate and latch the winner, then enter GRANT at the next edge with DACK[winner], activeCh and chValid asserted (1-cycle HLDA-to-DACK latency).
REQ-021 With commandReg[4]=0 (fixed priority), channel 0 SHALL be highest and channel 3 lowest.
REQ-022 With commandReg[4]=1 (rotating priority), the highest channel SHALL be prioPtr and the order SHALL be prioPtr, prioPtr+1, ... modulo 4.
REQ-023 prioPtr SHALL update only on svcDone in GRANT with commandReg[4]=1, to (activeCh+1) mod 4.
REQ-024 The winner SHALL be locked for all of GRANT; new or higher-priority requests SHALL NOT preempt it.
REQ-025 On svcDone in GRANT, the FSM SHALL enter IDLE and deassert DACK, chValid and HRQ at the next edge; a pending request SHALL re-raise HRQ no earlier than one cycle later.
REQ-026 If HLDA falls while in GRANT without svcDone, the FSM SHALL abort to IDLE, deassert outputs at the next edge and leave prioPtr unchanged.
REQ-027 Setting commandReg[2] during GRANT SHALL NOT abort the current service.
REQ-028 When svcDone and an HLDA drop occur in the same cycle, svcDone SHALL take precedence and prioPtr SHALL update.
REQ-029 DACK SHALL equal grantVec XOR {4{~commandReg[7]}}, where grantVec is a registered one-hot vector (zero when not in GRANT).
REQ-030 HRQ SHALL remain high throughout HOLD_REQ and GRANT.

Reset
REQ-031 While RESET is asserted, the FSM SHALL be IDLE, HRQ=0, grantVec=0, activeCh=0, chValid=0, prioPtr=0 and all synchronizer flops =0.
REQ-032 RESET asserted mid-GRANT SHALL clear all state immediately, without waiting for a clock edge.

Structure
REQ-033 The shared package dma_pkg SHALL hold the FSM state enum, NUM_CH=4, and named bit indices for commandReg (CMD_DISABLE=2, CMD_ROTATE=4, CMD_DREQ_LO=6, CMD_DACK_HI=7).
REQ-034 The block SHALL contain exactly one sub-module, dma_dreq_sync, a parameterized multi-bit synchronizer instantiated once.

Verification
REQ-035 The bench SHALL cover fixed priority: DREQ=4'b1010, HLDA raised -> DACK selects ch1, activeCh=1; after svcDone the next grant goes to ch3.
REQ-036 The bench SHALL cover rotating priority: cmd[4]=1, ch2 serviced, then DREQ=4'b1111 -> next grant ch3, then ch0, then ch1.
REQ-037 The bench SHALL cover masking and software requests: maskReg=4'h1, DREQ[0]=1 -> HRQ stays 0; requestReg=4'h1 -> HRQ=1 and ch0 is granted.
REQ-038 The bench SHALL cover withdrawal and abort: DREQ dropped in HOLD_REQ -> HRQ=0 one edge later; HLDA dropped in GRANT -> DACK inactive and prioPtr unchanged.
REQ-039 The bench SHALL cover polarity: cmd[6]=1 with DREQ=4'b1110 -> ch0 requests; cmd[7]=0 -> idle DACK=4'hF and granted ch0 gives DACK=4'hE.
REQ-040 The bench SHALL cover asynchronous reset mid-GRANT: all outputs go to reset values without a clock edge, and prioPtr=0.
